// File: rtl/cla_pkg.sv
// Shared carry-look-ahead definitions: group size and the 4-bit carry expansion
// used both inside a group and across groups.
package cla_pkg;

    localparam int CLA_GROUP = 4;

    // Returns {c4, c3, c2, c1, c0}; every carry is a flat sum of products, no ripple.
    function automatic logic [4:0] cla_carry(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c0
    );
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic cla_carry_at(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c0,
        input logic [2:0] idx
    );
        logic [4:0] c;
        c = cla_carry(g, p, c0);
        return c[idx];
    endfunction

endpackage

// File: rtl/cla4_block.sv
// 4-bit look-ahead group: sum plus group generate/propagate.
// Purely combinational, no backpressure.
module cla4_block
    import cla_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 cin,
    output logic [CLA_GROUP-1:0] sum,
    output logic                 g_grp,
    output logic                 p_grp
);

    logic [CLA_GROUP-1:0] g;
    logic [CLA_GROUP-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        sum = '0;
        for (int i = 0; i < CLA_GROUP; i++) begin
            sum[i] = p[i] ^ cla_carry_at(g, p, cin, 3'(i));
        end
    end

    // Group generate is c4 with no carry in, so it never depends on cin.
    assign g_grp = cla_carry_at(g, p, 1'b0, 3'd4);
    assign p_grp = &p;

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Registered two-level carry-look-ahead adder with cascadable group P/G.
// Latency 1 cycle, result every valid cycle, no backpressure.
module carry_look_ahead_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             P_grp,
    output logic             G_grp,
    output logic             out_valid
);

    localparam int NG = WIDTH / CLA_GROUP;

    if ((WIDTH % CLA_GROUP) != 0 || WIDTH < CLA_GROUP) begin : g_bad_width
        $error("carry_look_ahead_adder: WIDTH must be a positive multiple of 4");
    end

    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] sum_nxt;
    logic             p_nxt;
    logic             cout_nxt;
    logic             g_nxt;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla4_block u_blk (
            .a     (A[k*CLA_GROUP +: CLA_GROUP]),
            .b     (B[k*CLA_GROUP +: CLA_GROUP]),
            .cin   (grp_c[k]),
            .sum   (sum_nxt[k*CLA_GROUP +: CLA_GROUP]),
            .g_grp (grp_g[k]),
            .p_grp (grp_p[k])
        );
    end

    if (NG <= CLA_GROUP) begin : g_lvl2_fn
        // Unused upper group slots are padded with p=g=0; their carries are never read.
        logic [3:0] gpad;
        logic [3:0] ppad;

        always_comb begin
            gpad          = '0;
            ppad          = '0;
            gpad[NG-1:0]  = grp_g;
            ppad[NG-1:0]  = grp_p;
            grp_c         = '0;
            grp_c[0]      = Cin;
            for (int k = 1; k <= NG; k++) begin
                grp_c[k] = cla_carry_at(gpad, ppad, Cin, 3'(k));
            end
        end
    end else begin : g_lvl2_wide
        // Each group carry is the OR of G_j gated by the AND of all P above j.
        logic run;
        logic acc;

        always_comb begin
            run      = 1'b1;
            acc      = 1'b0;
            grp_c    = '0;
            grp_c[0] = Cin;
            for (int k = 1; k <= NG; k++) begin
                run = 1'b1;
                acc = 1'b0;
                for (int j = k - 1; j >= 0; j--) begin
                    acc = acc | (run & grp_g[j]);
                    run = run & grp_p[j];
                end
                grp_c[k] = acc | (run & Cin);
            end
        end
    end

    assign p_nxt    = &grp_p;
    assign cout_nxt = grp_c[NG];
    // With P=1 every bit propagates so G must be 0; with P=0 Cout equals G.
    assign g_nxt    = cout_nxt & ~p_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S         <= '0;
            Cout      <= 1'b0;
            P_grp     <= 1'b0;
            G_grp     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S     <= sum_nxt;
                Cout  <= cout_nxt;
                P_grp <= p_nxt;
                G_grp <= g_nxt;
            end
        end
    end

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Bench for carry_look_ahead_adder at WIDTH=4 (directed + exhaustive) and WIDTH=8 (random + reset).
module tb_carry_look_ahead_adder;

    logic clk = 1'b0;
    logic rst_n;

    logic [3:0] a4, b4, s4;
    logic       cin4, v4, co4, pg4, gg4, ov4;
    logic [7:0] a8, b8, s8;
    logic       cin8, v8, co8, pg8, gg8, ov8;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries: {cout, p, g, sum}
    logic [6:0]  q4[$];
    logic [10:0] q8[$];
    logic [6:0]  last4;

    always #5 clk = ~clk;

    carry_look_ahead_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4), .in_valid(v4),
        .S(s4), .Cout(co4), .P_grp(pg4), .G_grp(gg4), .out_valid(ov4)
    );

    carry_look_ahead_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8), .in_valid(v8),
        .S(s8), .Cout(co8), .P_grp(pg8), .G_grp(gg8), .out_valid(ov8)
    );

    function automatic logic [6:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] t, t0;
        t  = {1'b0, a} + {1'b0, b} + {4'b0, c};
        t0 = {1'b0, a} + {1'b0, b};
        return {t[4], &(a ^ b), t0[4], t[3:0]};
    endfunction

    function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t, t0;
        t  = {1'b0, a} + {1'b0, b} + {8'b0, c};
        t0 = {1'b0, a} + {1'b0, b};
        return {t[8], &(a ^ b), t0[8], t[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ov4"}, 32'(ov4), 32'd0);
        chk({tag, "_s4"},  32'(s4),  32'd0);
        chk({tag, "_co4"}, 32'(co4), 32'd0);
        chk({tag, "_pg4"}, 32'(pg4), 32'd0);
        chk({tag, "_gg4"}, 32'(gg4), 32'd0);
        chk({tag, "_ov8"}, 32'(ov8), 32'd0);
        chk({tag, "_s8"},  32'(s8),  32'd0);
        chk({tag, "_co8"}, 32'(co8), 32'd0);
    endtask

    task automatic check4();
        logic [6:0] e;
        chk("w4_out_valid", 32'(ov4), 32'd1);
        chk("w4_sb_depth", 32'(q4.size()), 32'd1);
        if (q4.size() != 0) begin
            e = q4.pop_front();
            chk("w4_S",    32'(s4),  32'(e[3:0]));
            chk("w4_Cout", 32'(co4), 32'(e[6]));
            chk("w4_P",    32'(pg4), 32'(e[5]));
            chk("w4_G",    32'(gg4), 32'(e[4]));
            last4 = e;
        end
    endtask

    task automatic check8();
        logic [10:0] e;
        chk("w8_out_valid", 32'(ov8), 32'd1);
        chk("w8_sb_depth", 32'(q8.size()), 32'd1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("w8_S",    32'(s8),  32'(e[7:0]));
            chk("w8_Cout", 32'(co8), 32'(e[10]));
            chk("w8_P",    32'(pg8), 32'(e[9]));
            chk("w8_G",    32'(gg8), 32'(e[8]));
        end
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; v4 = 1'b1;
        q4.push_back(model4(a, b, c));
        @(posedge clk);
        #1;
        check4();
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; v8 = 1'b1;
        q8.push_back(model8(a, b, c));
        @(posedge clk);
        #1;
        check8();
    endtask

    task automatic hold4(input string tag);
        @(negedge clk);
        v4 = 1'b0; a4 = 'x; b4 = 'x; cin4 = 1'bx;
        @(posedge clk);
        #1;
        chk({tag, "_ov"},   32'(ov4), 32'd0);
        chk({tag, "_S"},    32'(s4),  32'(last4[3:0]));
        chk({tag, "_Cout"}, 32'(co4), 32'(last4[6]));
        chk({tag, "_P"},    32'(pg4), 32'(last4[5]));
        chk({tag, "_G"},    32'(gg4), 32'(last4[4]));
    endtask

    initial begin
        logic [8:0] vec;
        logic [7:0] ra, rb;

        rst_n = 1'b1;
        a4 = '0; b4 = '0; cin4 = 1'b0; v4 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; v8 = 1'b0;

        // Asynchronous reset between clock edges
        #3 rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed WIDTH=4 cases
        drive4(4'b0001, 4'b0010, 1'b0);
        drive4(4'b1111, 4'b1111, 1'b1);
        drive4(4'b0011, 4'b0101, 1'b0);
        drive4(4'b1010, 4'b0101, 1'b1);
        hold4("hold_a");
        hold4("hold_b");

        // Exhaustive WIDTH=4, back-to-back
        for (int i = 0; i < 512; i++) begin
            vec = 9'(i);
            drive4(vec[3:0], vec[7:4], vec[8]);
        end
        @(negedge clk);
        v4 = 1'b0;

        // WIDTH=8 boundaries, then random stream with a reset pulse mid-stream
        drive8(8'hFF, 8'hFF, 1'b1);
        drive8(8'hA5, 8'h5A, 1'b1);
        for (int i = 0; i < 80; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 40) begin
                @(negedge clk);
                a8 = ra; b8 = rb; cin8 = 1'b1; v8 = 1'b1;
                q8.push_back(model8(ra, rb, 1'b1));
                #2 rst_n = 1'b0;
                @(posedge clk);
                #1;
                check_zero("rst_mid");
                q8.delete();
                #1 rst_n = 1'b1;
            end else begin
                drive8(ra, rb, 1'($urandom));
            end
        end
        @(negedge clk);
        v8 = 1'b0;
        @(posedge clk);
        #1;
        chk("w8_idle_ov", 32'(ov8), 32'd0);
        chk("sb4_drained", 32'(q4.size()), 32'd0);
        chk("sb8_drained", 32'(q8.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
